// File: rtl/ifu_ir_buf_pkg.sv
// Shared IFU/EXU instruction-register definitions: default widths,
// attribute bundle, entry-width helper and RV32 length detection.
package ifu_ir_buf_pkg;

    localparam int PC_SIZE    = 32;
    localparam int INSTR_SIZE = 32;

    // Fetch attributes carried alongside each instruction
    localparam int ATTR_W = 4;

    // RV32 length-detect field positions (shared with exu_decode)
    localparam int RV32_OP_LSB = 0;
    localparam int RV32_OP_MSB = 1;
    localparam int RV32_EX_LSB = 2;
    localparam int RV32_EX_MSB = 4;

    typedef struct packed {
        logic prdt_taken;
        logic misalgn;
        logic buserr;
        logic muldiv_b2b;
    } ir_attr_t;

    // Packed entry width: instr + pc + attributes
    function automatic int entry_width(input int pc_w, input int ir_w);
        return ir_w + pc_w + ATTR_W;
    endfunction

    // 32-bit encoding: low two bits 11 and bits [4:2] not 111
    function automatic logic is_rv32(input logic [4:0] lo);
        return (lo[RV32_OP_MSB:RV32_OP_LSB] == 2'b11) &&
               (lo[RV32_EX_MSB:RV32_EX_LSB] != 3'b111);
    endfunction

endpackage

// File: rtl/ifu_ir_fifo_mem.sv
// Instruction-register FIFO storage: DEPTH x W flops, one write port,
// asynchronous read port, cleared on reset.
// Ports: clk, rst, i_we, i_waddr, i_wdata, i_raddr, o_rdata.
module ifu_ir_fifo_mem
    import ifu_ir_buf_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = entry_width(PC_SIZE, INSTR_SIZE),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ifu_ir_buf.sv
// IFU -> EXU instruction register buffer: in-order FIFO of fetched
// instructions with PC and attributes, valid/ready on both sides.
// Ports: clk, rst; fetch side i_valid/i_ready/i_instr/i_pc/i_<attr>;
// flush_req; decode side o_valid/o_ready/o_instr/o_pc/o_<attr>/o_rv32;
// ir_empty.
module ifu_ir_buf
    import ifu_ir_buf_pkg::*;
#(
    parameter int PC_SIZE    = ifu_ir_buf_pkg::PC_SIZE,
    parameter int INSTR_SIZE = ifu_ir_buf_pkg::INSTR_SIZE,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [INSTR_SIZE-1:0] i_instr,
    input  logic [PC_SIZE-1:0]    i_pc,
    input  logic                  i_prdt_taken,
    input  logic                  i_misalgn,
    input  logic                  i_buserr,
    input  logic                  i_muldiv_b2b,
    input  logic                  flush_req,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [INSTR_SIZE-1:0] o_instr,
    output logic [PC_SIZE-1:0]    o_pc,
    output logic                  o_prdt_taken,
    output logic                  o_misalgn,
    output logic                  o_buserr,
    output logic                  o_muldiv_b2b,
    output logic                  o_rv32,
    output logic                  ir_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = entry_width(PC_SIZE, INSTR_SIZE);

    localparam logic [AW:0]   L_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   L_CNT1 = (AW+1)'(1);
    localparam logic [AW-1:0] L_PTR1 = AW'(1);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;

    logic          w_push;
    logic          w_pop;
    logic          w_we;
    logic [EW-1:0] w_wdata;
    logic [EW-1:0] w_rdata;
    ir_attr_t      w_attr;

    // Ready depends on stored count only, so no o_ready -> i_ready path
    assign i_ready  = (r_count != L_FULL);
    assign o_valid  = (r_count != '0);
    assign ir_empty = (r_count == '0);

    assign w_push = i_valid & i_ready;
    assign w_pop  = o_valid & o_ready;
    // A push coincident with flush is dropped
    assign w_we   = w_push & ~flush_req;

    assign w_attr.prdt_taken = i_prdt_taken;
    assign w_attr.misalgn    = i_misalgn;
    assign w_attr.buserr     = i_buserr;
    assign w_attr.muldiv_b2b = i_muldiv_b2b;
    assign w_wdata = {i_instr, i_pc, w_attr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush_req) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + L_PTR1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + L_PTR1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + L_CNT1;
                2'b01:   r_count <= r_count - L_CNT1;
                default: r_count <= r_count;
            endcase
        end
    end

    ifu_ir_fifo_mem #(
        .DEPTH (DEPTH),
        .W     (EW),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rptr),
        .o_rdata (w_rdata)
    );

    assign {o_instr, o_pc,
            o_prdt_taken, o_misalgn,
            o_buserr, o_muldiv_b2b} = w_rdata;

    assign o_rv32 = is_rv32(o_instr[4:0]);

endmodule
